// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: queues 8088-style bus requests and plays them out as
// ACTIVE/TAIL/GAP status sequences, with wait states and locked INTA pairs.
module bus_cycle_sequencer #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 4,
    parameter int T_STATES    = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [2:0]                       req_type,
    input  logic [ADDR_WIDTH-1:0]            req_address,
    input  logic [DATA_WIDTH-1:0]            req_data,
    output logic [2:0]                       processor_status,
    output logic                             processor_lock_n,
    output logic [ADDR_WIDTH-1:0]            cpu_address,
    output logic [DATA_WIDTH-1:0]            cpu_data_out,
    output logic                             cpu_data_oe,
    input  logic [DATA_WIDTH-1:0]            cpu_data_in,
    input  logic                             processor_ready,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count,
    output logic                             busy
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int QW = PW + 1;
    localparam int EW = 3 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(T_STATES > GAP_CYCLES ? T_STATES : GAP_CYCLES) + 1;
    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, TAIL = 2'd2, GAP = 2'd3;

    logic [EW-1:0]         mem [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [QW-1:0]         count;
    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [2:0]            cur_type;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  second;
    logic                  push, pop, on_bus, is_read, is_write, is_halt, is_inta;

    assign req_ready = reset_n && (count < QW'(QUEUE_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign on_bus    = (state == ACTIVE) || (state == TAIL);
    assign is_read   = !cur_type[1];
    assign is_write  = cur_type[1] && !cur_type[0];
    assign is_halt   = cur_type == 3'b011;
    assign is_inta   = cur_type == 3'b000;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_type, req_address, req_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + QW'(push) - QW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_type <= 3'b111;
            cur_addr <= '0;
            cur_data <= '0;
            second   <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {cur_type, cur_addr, cur_data} <= mem[rd_ptr];
                    second <= 1'b0;
                    cnt    <= '0;
                    // a type-111 entry is simply dropped
                    state  <= (mem[rd_ptr][EW-1 -: 3] == 3'b111) ? IDLE : ACTIVE;
                end
                ACTIVE: if (cnt != CW'(T_STATES - 1)) cnt <= cnt + 1'b1;
                    else if (processor_ready || is_halt) begin
                        state <= TAIL;
                        if (is_read) rsp_data <= cpu_data_in;
                    end
                TAIL: begin
                    state <= GAP;
                    cnt   <= '0;
                end
                default: if (cnt != CW'(GAP_CYCLES - 1)) cnt <= cnt + 1'b1;
                    else if (is_inta && !second) begin
                        state  <= ACTIVE;
                        second <= 1'b1;
                        cnt    <= '0;
                    end else state <= IDLE;
            endcase
        end
    end

    // lock spans both INTA halves, including the gap between them
    assign processor_lock_n = !(is_inta && (on_bus || (state == GAP && !second)));
    assign processor_status = (state == ACTIVE) ? cur_type : 3'b111;
    assign cpu_address      = on_bus ? cur_addr : '0;
    assign cpu_data_oe      = on_bus && is_write;
    assign cpu_data_out     = cpu_data_oe ? cur_data : '0;
    assign rsp_valid        = (state == TAIL) && is_read && (!is_inta || second);
    assign queue_count      = count;
    assign busy             = (state != IDLE) || (count != '0);
endmodule
